// File: rtl/slot_state_table.sv
// Slot-state word table: single read-before-write port with bit-masked writes,
// range checking, and a clear sequencer that sweeps INIT_VAL through every entry.
module slot_state_table #(
    parameter int                DATA_W   = 14,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              addr_err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_access;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: if (r_ptr == LP_LAST) w_next_state = S_IDLE;
            S_IDLE:  if (clr_req)          w_next_state = S_CLEAR;
            default: w_next_state = S_CLEAR;
        endcase
    end

    // A clear request in IDLE steals the cycle from any same-cycle access.
    always_comb begin
        busy       = (r_state == S_CLEAR);
        w_access   = (r_state == S_IDLE) && !clr_req && (ren || wen);
        w_in_range = ({1'b0, addr} < LP_DEPTH);
        w_rd_word  = r_mem[addr[IDX_W-1:0]];
        w_mem_we   = busy || (w_access && wen && w_in_range);
        w_mem_addr = busy ? r_ptr : addr;
        w_mem_wdat = busy ? INIT_VAL : ((w_rd_word & ~wmask) | (wdata & wmask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE || r_ptr == LP_LAST) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr[IDX_W-1:0]] <= w_mem_wdat;
        end
    end

    // rdata samples the array at the same edge as the write, so it returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= w_access;
            addr_err <= w_access && !w_in_range;
            if (w_access) begin
                rdata <= w_in_range ? w_rd_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_slot_state_table.sv
// Directed bench for slot_state_table with DEPTH=16 and INIT_VAL=14'h155.
module tb_slot_state_table;

    localparam int          DW    = 14;
    localparam int          AW    = 10;
    localparam int          DEP   = 16;
    localparam logic [13:0] IV    = 14'h155;

    logic          clk;
    logic          rst;
    logic          clr_req;
    logic          busy;
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          addr_err;

    int checks = 0;
    int errors = 0;

    slot_state_table #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEP),
        .INIT_VAL(IV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .wen     (wen),
        .ren     (ren),
        .addr    (addr),
        .wdata   (wdata),
        .wmask   (wmask),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v_wen;
        logic          v_ren;
        logic [AW-1:0] v_addr;
        logic [DW-1:0] v_wdata;
        logic [DW-1:0] v_wmask;
        logic          e_rvalid;
        logic          e_err;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen = 1'b0; ren = 1'b0; clr_req = 1'b0;
        addr = '0; wdata = '0; wmask = '0;
    endtask

    task automatic count_busy(input int start, output int cnt);
        int guard;
        cnt = start;
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
            if (busy) cnt++;
        end
    endtask

    task automatic rd(input int a, input logic [DW-1:0] exp, input string name);
        ren = 1'b1; addr = AW'(a);
        step();
        ren = 1'b0;
        chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({name, "_rdata"}, 32'(rdata), 32'(exp));
    endtask

    initial begin
        int n;
        logic [DW-1:0] exp_word;

        vecs[0]  = '{1'b1, 1'b0, 10'd5,   14'h2A3A, 14'h3FFF, 1'b1, 1'b0, 14'h155};
        vecs[1]  = '{1'b0, 1'b1, 10'd5,   14'h0000, 14'h0000, 1'b1, 1'b0, 14'h2A3A};
        vecs[2]  = '{1'b1, 1'b0, 10'd5,   14'h3FFF, 14'h000F, 1'b1, 1'b0, 14'h2A3A};
        vecs[3]  = '{1'b1, 1'b0, 10'd5,   14'h0000, 14'h0000, 1'b1, 1'b0, 14'h2A3F};
        vecs[4]  = '{1'b0, 1'b1, 10'd5,   14'h0000, 14'h0000, 1'b1, 1'b0, 14'h2A3F};
        vecs[5]  = '{1'b1, 1'b0, 10'd20,  14'h1234, 14'h3FFF, 1'b1, 1'b1, 14'h0000};
        vecs[6]  = '{1'b0, 1'b0, 10'd4,   14'h0000, 14'h0000, 1'b0, 1'b0, 14'h0000};
        vecs[7]  = '{1'b0, 1'b1, 10'd4,   14'h0000, 14'h0000, 1'b1, 1'b0, 14'h155};
        vecs[8]  = '{1'b0, 1'b1, 10'd15,  14'h0000, 14'h0000, 1'b1, 1'b0, 14'h155};
        vecs[9]  = '{1'b0, 1'b1, 10'd16,  14'h0000, 14'h0000, 1'b1, 1'b1, 14'h0000};
        vecs[10] = '{1'b1, 1'b0, 10'd0,   14'h0AAA, 14'h0F0F, 1'b1, 1'b0, 14'h155};
        vecs[11] = '{1'b1, 1'b1, 10'd0,   14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 14'h0A5A};
        vecs[12] = '{1'b0, 1'b1, 10'd0,   14'h0000, 14'h0000, 1'b1, 1'b0, 14'h3FFF};
        vecs[13] = '{1'b0, 1'b1, 10'd1023, 14'h0000, 14'h0000, 1'b1, 1'b1, 14'h0000};

        idle_inputs();
        rst = 1'b1;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);

        // First sweep, then fill with garbage through the port so the next sweep has work to do.
        rst = 1'b0;
        count_busy(1, n);
        for (int i = 0; i < DEP; i++) begin
            wen = 1'b1; addr = AW'(i); wdata = DW'(14'h3A5A ^ i); wmask = 14'h3FFF;
            step();
        end
        idle_inputs();
        rd(9, DW'(14'h3A5A ^ 9), "garbage9");

        rst = 1'b1;
        step();
        chk("rst2_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        count_busy(1, n);
        chk("sweep_len", 32'(n), 32'd16);

        for (int i = 0; i < DEP; i++) rd(i, IV, $sformatf("init%0d", i));
        step();
        chk("hold_rvalid", 32'(rvalid), 32'd0);
        chk("hold_rdata", 32'(rdata), 32'(IV));

        for (int i = 0; i < 14; i++) begin
            wen = vecs[i].v_wen; ren = vecs[i].v_ren; addr = vecs[i].v_addr;
            wdata = vecs[i].v_wdata; wmask = vecs[i].v_wmask;
            step();
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].e_rvalid));
            chk($sformatf("vec%0d_err", i), 32'(addr_err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
        end
        idle_inputs();
        step();
        chk("err_pulse", 32'(addr_err), 32'd0);

        for (int i = 0; i < DEP; i++) begin
            exp_word = (i == 0) ? 14'h3FFF : (i == 5) ? 14'h2A3F : IV;
            rd(i, exp_word, $sformatf("after%0d", i));
        end

        // Clear request with a same-cycle write; a second request mid-sweep is ignored.
        clr_req = 1'b1; wen = 1'b1; addr = 10'd3; wdata = 14'h1111; wmask = 14'h3FFF;
        step();
        idle_inputs();
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_rvalid", 32'(rvalid), 32'd0);
        n = 1;
        for (int g = 0; g < 100 && busy; g++) begin
            ren = 1'b1; addr = 10'd3; clr_req = (n == 5);
            step();
            chk($sformatf("busy_drop%0d", g), 32'(rvalid), 32'd0);
            if (busy) n++;
        end
        idle_inputs();
        chk("clr_len", 32'(n), 32'd16);
        rd(3, IV, "clr3");
        rd(5, IV, "clr5");
        rd(0, IV, "clr0");

        // Reset partway through a sweep restarts it from the beginning.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("midrst_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("midrst_rdata%0d", i), 32'(rdata), 32'd0);
        end
        rst = 1'b0;
        count_busy(1, n);
        chk("midrst_len", 32'(n), 32'd16);
        rd(15, IV, "midrst15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_state_table.md
Name: slot_state_table

Overview:
Parametrised successor to the slot-state RAM, storing per-slot MAC time-slot state words. It has the following features:
- Synchronous read-before-write port.
- Bit-masked writes.
- Address range checking.
- Hardware clear sequencer that initialises every entry after reset or on request.

It sits between the slot scheduler and the MAC control FSM. The scheduler reads and updates slot state words through a single port.

Parameters:
DATA_W, 14, width of one slot state word
ADDR_W, 10, address width
DEPTH, 1024, number of valid entries (DEPTH <= 2**ADDR_W)
INIT_VAL, 0, value written to every entry by the clear sequencer

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
clr_req  in  1  single-cycle request to re-clear the whole table
busy  out  1  high while the clear sequencer owns the memory
wen  in  1  write enable for the access port
ren  in  1  read enable for the access port
addr  in  ADDR_W  access address
wdata  in  DATA_W  write data
wmask  in  DATA_W  per-bit write mask; 1 = update bit
rdata  out  DATA_W  registered read data
rvalid  out  1  one-cycle pulse qualifying rdata
addr_err  out  1  one-cycle pulse: access to addr >= DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - rdata = 0, rvalid = 0, addr_err = 0.
  - busy = 1; FSM = CLEAR; clear pointer = 0.
  - Memory array is not reset directly; the sweep initialises it.
- FSM states are CLEAR and IDLE.
- CLEAR state:
  - Each cycle, write INIT_VAL to mem[ptr], then ptr <= ptr+1.
  - When ptr == DEPTH-1 is written, go to IDLE next cycle; busy falls to 0 on that transition.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
- IDLE state:
  - clr_req=1 -> CLEAR next cycle with ptr=0 and busy=1.
  - clr_req in CLEAR is ignored; the sweep does not restart.
  - In IDLE, clr_req takes priority over a same-cycle access; that access is dropped.
- Access port:
  - Honoured only in IDLE with clr_req=0. Accesses while busy=1 are dropped silently: no rvalid, no write, no addr_err.
- Read (ren=1 or wen=1, addr < DEPTH):
  - rdata <= mem[addr] as it was before any same-cycle write (read-before-write).
  - rvalid=1 in the following cycle; latency is 1 clock.
- Write (wen=1, addr < DEPTH):
  - mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask).
  - wmask = all-ones is a full write; wmask = 0 leaves the entry unchanged but still returns old data.
- Out of range (addr >= DEPTH with ren or wen):
  - No write is performed.
  - rdata <= 0, rvalid=1, addr_err=1 for one cycle.
- rdata holds its last value when rvalid=0.
- Back-to-back:
  - An access to the same address in consecutive cycles sees the previous cycle's write.
  - The mask merge uses the current array contents; no stale forwarding hazard, since reads are registered from the array at the same edge.
- Reset mid-sweep or mid-access:
  - Immediate return to reset values.
  - Sweep restarts from 0 when rst deasserts.
  - Partially written contents are irrelevant.

Test Plan:
- DEPTH=16, INIT_VAL=14'h155; preload garbage via backdoor, release rst -> busy=1 for exactly 16 cycles then 0; reads of all 16 addresses return 14'h155 with rvalid one cycle after each ren.
- After clear: write addr 5 = 14'h2A3A with wmask=all-ones and wen=1 -> rdata=14'h155 (old value) next cycle; subsequent read of addr 5 -> 14'h2A3A.
- Masked write to addr 5, wdata=14'h3FFF, wmask=14'h000F -> entry becomes 14'h2A3F; with wmask=0 the entry is unchanged and returns 14'h2A3F.
- Access addr 20 with DEPTH=16, wen=1, wdata=14'h1234 -> addr_err=1, rvalid=1, rdata=0; entries 0..15 unchanged; addr 4 (20 mod 16) still holds its old value.
- In IDLE assert clr_req together with wen to addr 3 -> write dropped; busy=1 for 16 cycles; a ren issued during busy produces no rvalid; afterwards addr 3 = INIT_VAL. A second clr_req pulsed mid-sweep does not extend busy.
- Assert rst at sweep cycle 7, release 3 cycles later -> busy stays 1, sweep restarts, and busy falls exactly 16 cycles after release.
